// File: rtl/esaxi_wr_pkg.sv
// Shared AXI slave definitions: burst types, response codes and the
// write-channel FSM state encoding. Imported by esaxi_wr and emaxi.
package esaxi_wr_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage : esaxi_wr_pkg

// File: rtl/esaxi_wr_addr_gen.sv
// Burst address generator (combinational).
// Ports:
//   addr_i      current beat address (burst start address on beat 0)
//   size_i      log2 bytes per beat
//   burst_i     burst type
//   next_addr_o address of the following beat (truncated to AW bits)
//   illegal_o   burst type or size not supported by this slave
module esaxi_addr_gen
  import esaxi_wr_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 64
) (
  input  logic [AW-1:0] addr_i,
  input  logic [2:0]    size_i,
  input  logic [1:0]    burst_i,
  output logic [AW-1:0] next_addr_o,
  output logic          illegal_o
);

  localparam int unsigned MAX_SIZE = $clog2(DW / 8);

  // INCR advances by the beat size; FIXED (and illegal types) hold the address
  always_comb begin
    next_addr_o = addr_i;
    if (burst_i == BURST_INCR) begin
      next_addr_o = addr_i + (AW'(1) << size_i);
    end
    illegal_o = (burst_i == BURST_WRAP) || (burst_i == BURST_RSVD) ||
                (32'(size_i) > MAX_SIZE);
  end

endmodule : esaxi_addr_gen

// File: rtl/esaxi.sv
// AXI slave write channel to simple memory write port.
// One burst in flight: AW captured in IDLE, beats written in DATA,
// single B response in RESP. Protocol violations turn the rest of the
// burst into dropped writes and an SLVERR response.
// Ports:
//   s_axi_aw*  write address channel (awready registered)
//   s_axi_w*   write data channel (wready = ~mem_wait while in DATA)
//   s_axi_b*   write response channel
//   mem_*      zero-latency memory write port, mem_wait stalls W
module esaxi_wr
  import esaxi_wr_pkg::*;
#(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 64,
  parameter int unsigned IDW = 12
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic [IDW-1:0]    s_axi_awid,
  input  logic [AW-1:0]     s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic [2:0]        s_axi_awsize,
  input  logic [1:0]        s_axi_awburst,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [IDW-1:0]    s_axi_wid,
  input  logic [DW-1:0]     s_axi_wdata,
  input  logic [DW/8-1:0]   s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [IDW-1:0]    s_axi_bid,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic [DW/8-1:0]   mem_wstrb,
  input  logic              mem_wait
);

  state_e         state_q, state_d;
  logic           awready_q, awready_d;
  logic [IDW-1:0] id_q, id_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [7:0]     len_q, len_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [2:0]     size_q, size_d;
  logic [1:0]     burst_q, burst_d;
  logic           err_q, err_d;

  logic [AW-1:0]  next_addr;
  logic           illegal;
  logic           last_beat;
  logic           beat_err;

  esaxi_addr_gen #(.AW(AW), .DW(DW)) u_addr_gen (
    .addr_i      (addr_q),
    .size_i      (size_q),
    .burst_i     (burst_q),
    .next_addr_o (next_addr),
    .illegal_o   (illegal)
  );

  // State and captured burst context
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      state_q   <= ST_IDLE;
      awready_q <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      err_q     <= err_d;
    end
  end

  // Next state, channel handshakes and memory strobe
  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    addr_d       = addr_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    size_d       = size_q;
    burst_d      = burst_q;
    err_d        = err_q;
    s_axi_wready = 1'b0;
    s_axi_bvalid = 1'b0;
    s_axi_bresp  = RESP_OKAY;
    mem_we       = 1'b0;

    last_beat = (cnt_q == len_q);
    // Current beat is bad if the burst is already bad or this beat breaks protocol
    beat_err  = err_q || illegal || (s_axi_wid != id_q) || (s_axi_wlast != last_beat);

    unique case (state_q)
      ST_IDLE: begin
        if (s_axi_awvalid && awready_q) begin
          id_d    = s_axi_awid;
          addr_d  = s_axi_awaddr;
          len_d   = s_axi_awlen;
          size_d  = s_axi_awsize;
          burst_d = s_axi_awburst;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        // Gated by reset so an abandoned burst never strobes memory
        s_axi_wready = ~mem_wait & s_axi_aresetn;
        if (s_axi_wvalid && s_axi_wready) begin
          mem_we = ~beat_err;
          err_d  = beat_err;
          addr_d = next_addr;
          if (last_beat) begin
            state_d = ST_RESP;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_RESP: begin
        s_axi_bvalid = s_axi_aresetn;
        s_axi_bresp  = err_q ? RESP_SLVERR : RESP_OKAY;
        if (s_axi_bready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    awready_d = (state_d == ST_IDLE);
  end

  assign s_axi_awready = awready_q;
  assign s_axi_bid     = id_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = s_axi_wdata;
  assign mem_wstrb     = s_axi_wstrb;

endmodule : esaxi_wr

// File: tb/tb_esaxi_wr.sv
// Self-checking bench for esaxi_wr: scoreboard of expected memory writes
// and B responses, consumed by a monitor as the DUT produces them.
module tb_esaxi_wr;
  import esaxi_wr_pkg::*;

  typedef struct packed {
    logic [31:0] a;
    logic [63:0] d;
    logic [7:0]  s;
  } wr_t;

  typedef struct packed {
    logic [11:0] id;
    logic [1:0]  r;
  } b_t;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [11:0] awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [11:0] wid;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [11:0] bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_wait;

  int cmp_cnt = 0;
  int err_cnt = 0;

  wr_t exp_w[$];
  b_t  exp_b[$];
  wr_t mw;
  b_t  mb;

  always #5 clk = ~clk;

  esaxi_wr #(.AW(32), .DW(64), .IDW(12)) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (aresetn),
    .s_axi_awid    (awid),
    .s_axi_awaddr  (awaddr),
    .s_axi_awlen   (awlen),
    .s_axi_awsize  (awsize),
    .s_axi_awburst (awburst),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wid     (wid),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wlast   (wlast),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bid     (bid),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_wait      (mem_wait)
  );

  // Scoreboard consumer: every memory write and B handshake is popped and compared
  always @(negedge clk) begin
    if (mem_we) begin
      cmp_cnt++;
      if (exp_w.size() == 0) begin
        err_cnt++;
        $display("FAIL mem_write unexpected addr=%h data=%h", mem_addr, mem_wdata);
      end else begin
        mw = exp_w.pop_front();
        if (mem_addr !== mw.a || mem_wdata !== mw.d || mem_wstrb !== mw.s) begin
          err_cnt++;
          $display("FAIL mem_write got a=%h d=%h s=%h exp a=%h d=%h s=%h",
                   mem_addr, mem_wdata, mem_wstrb, mw.a, mw.d, mw.s);
        end
      end
    end
    if (bvalid && bready) begin
      cmp_cnt++;
      if (exp_b.size() == 0) begin
        err_cnt++;
        $display("FAIL b_resp unexpected bid=%h bresp=%b", bid, bresp);
      end else begin
        mb = exp_b.pop_front();
        if (bid !== mb.id || bresp !== mb.r) begin
          err_cnt++;
          $display("FAIL b_resp got bid=%h bresp=%b exp bid=%h bresp=%b", bid, bresp, mb.id, mb.r);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic send_aw(input logic [11:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!awready && n < 100) begin n++; @(negedge clk); end
    if (!awready) begin
      cmp_cnt++; err_cnt++;
      $display("FAIL aw_timeout awready=%b exp 1", awready);
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_beat(input logic [11:0] id, input logic [63:0] d, input logic [7:0] s,
                           input logic last);
    int n;
    wid = id; wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!wready && n < 100) begin n++; @(negedge clk); end
    if (!wready) begin
      cmp_cnt++; err_cnt++;
      $display("FAIL w_timeout wready=%b exp 1", wready);
    end
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic recv_b(input int stall);
    int n;
    n = 0;
    @(negedge clk);
    while (!bvalid && n < 100) begin n++; @(negedge clk); end
    if (!bvalid) begin
      cmp_cnt++; err_cnt++;
      $display("FAIL b_timeout bvalid=%b exp 1", bvalid);
    end
    repeat (stall) @(posedge clk);
    @(posedge clk); #1;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  // Complete burst; expected writes follow the bench's own address model
  task automatic run_burst(input logic [11:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic ok);
    logic [31:0] a;
    logic [63:0] d;
    logic [7:0]  s;
    send_aw(id, addr, len, size, burst);
    for (int i = 0; i <= int'(len); i++) begin
      d = {$urandom(), $urandom()};
      s = 8'($urandom());
      a = (burst == BURST_FIXED) ? addr : addr + (32'(i) << size);
      if (ok) exp_w.push_back(wr_t'{a: a, d: d, s: s});
      send_beat(id, d, s, i == int'(len));
    end
    exp_b.push_back(b_t'{id: id, r: ok ? RESP_OKAY : RESP_SLVERR});
    recv_b(0);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp_cnt++;
    if (awready !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b0 || bresp !== 2'b00 ||
        bid !== 12'h0 || mem_we !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_outputs got aw=%b w=%b bv=%b br=%b bid=%h we=%b exp all 0",
               awready, wready, bvalid, bresp, bid, mem_we);
    end
    @(posedge clk); #1;
    aresetn = 1'b1;
    @(negedge clk);
    cmp_cnt++;
    if (awready !== 1'b0) begin
      err_cnt++; $display("FAIL reset_release_early awready=%b exp 0", awready);
    end
    @(negedge clk);
    cmp_cnt++;
    if (awready !== 1'b1) begin
      err_cnt++; $display("FAIL reset_release_awready awready=%b exp 1", awready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_incr();
    run_burst(12'h05A, 32'h0000_1000, 8'd3, 3'd3, BURST_INCR, 1'b1);
  endtask

  task automatic test_fixed();
    run_burst(12'h123, 32'h0000_0020, 8'd1, 3'd3, BURST_FIXED, 1'b1);
  endtask

  task automatic test_wlast_early();
    logic [63:0] d0;
    d0 = 64'hDEAD_BEEF_0000_0001;
    send_aw(12'h033, 32'h0000_3000, 8'd2, 3'd3, BURST_INCR);
    exp_w.push_back(wr_t'{a: 32'h0000_3000, d: d0, s: 8'hFF});
    send_beat(12'h033, d0, 8'hFF, 1'b0);
    send_beat(12'h033, 64'h1111, 8'hFF, 1'b1);
    @(negedge clk);
    cmp_cnt++;
    if (bvalid !== 1'b0 || wready !== 1'b1) begin
      err_cnt++;
      $display("FAIL wlast_early_continue bvalid=%b wready=%b exp 0 1", bvalid, wready);
    end
    @(posedge clk); #1;
    send_beat(12'h033, 64'h2222, 8'hFF, 1'b1);
    exp_b.push_back(b_t'{id: 12'h033, r: RESP_SLVERR});
    recv_b(0);
  endtask

  task automatic test_illegal();
    // Wrong WID on beat 0, error sticks through the otherwise-good beat 1
    send_aw(12'h011, 32'h0000_4000, 8'd1, 3'd3, BURST_INCR);
    send_beat(12'h022, 64'hAAAA, 8'hFF, 1'b0);
    send_beat(12'h011, 64'hBBBB, 8'hFF, 1'b1);
    exp_b.push_back(b_t'{id: 12'h011, r: RESP_SLVERR});
    recv_b(0);
    run_burst(12'h044, 32'h0000_4000, 8'd1, 3'd2, BURST_WRAP, 1'b0);
    run_burst(12'h045, 32'h0000_4000, 8'd0, 3'd4, BURST_INCR, 1'b0);
    run_burst(12'h046, 32'h0000_4000, 8'd0, 3'd2, BURST_RSVD, 1'b0);
  endtask

  task automatic test_mem_wait();
    logic [63:0] d;
    send_aw(12'h066, 32'h0000_2000, 8'd3, 3'd2, BURST_INCR);
    for (int i = 0; i < 2; i++) begin
      d = {$urandom(), $urandom()};
      exp_w.push_back(wr_t'{a: 32'h0000_2000 + 32'(4 * i), d: d, s: 8'h0F});
      send_beat(12'h066, d, 8'h0F, 1'b0);
    end
    d = 64'h0123_4567_89AB_CDEF;
    exp_w.push_back(wr_t'{a: 32'h0000_2008, d: d, s: 8'hF0});
    mem_wait = 1'b1;
    wid = 12'h066; wdata = d; wstrb = 8'hF0; wlast = 1'b0; wvalid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      cmp_cnt++;
      if (wready !== 1'b0 || mem_we !== 1'b0) begin
        err_cnt++;
        $display("FAIL mem_wait_stall wready=%b mem_we=%b exp 0 0", wready, mem_we);
      end
    end
    @(posedge clk); #1;
    mem_wait = 1'b0;
    @(negedge clk);
    cmp_cnt++;
    if (wready !== 1'b1) begin
      err_cnt++; $display("FAIL mem_wait_release wready=%b exp 1", wready);
    end
    @(posedge clk); #1;
    wvalid = 1'b0;
    d = 64'hFEDC_BA98_7654_3210;
    exp_w.push_back(wr_t'{a: 32'h0000_200C, d: d, s: 8'hFF});
    send_beat(12'h066, d, 8'hFF, 1'b1);
    exp_b.push_back(b_t'{id: 12'h066, r: RESP_OKAY});
    recv_b(0);
  endtask

  task automatic test_b_stall();
    send_aw(12'h777, 32'h0000_5000, 8'd0, 3'd3, BURST_INCR);
    exp_w.push_back(wr_t'{a: 32'h0000_5000, d: 64'h5555, s: 8'h3C});
    send_beat(12'h777, 64'h5555, 8'h3C, 1'b1);
    exp_b.push_back(b_t'{id: 12'h777, r: RESP_OKAY});
    repeat (4) begin
      @(negedge clk);
      cmp_cnt++;
      if (bvalid !== 1'b1 || bid !== 12'h777 || awready !== 1'b0) begin
        err_cnt++;
        $display("FAIL b_stall_hold bvalid=%b bid=%h awready=%b exp 1 777 0", bvalid, bid, awready);
      end
    end
    @(posedge clk); #1;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    cmp_cnt++;
    if (bvalid !== 1'b0 || awready !== 1'b1) begin
      err_cnt++;
      $display("FAIL b_stall_done bvalid=%b awready=%b exp 0 1", bvalid, awready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    send_aw(12'h088, 32'h0000_6000, 8'd3, 3'd3, BURST_INCR);
    exp_w.push_back(wr_t'{a: 32'h0000_6000, d: 64'h6000, s: 8'hFF});
    send_beat(12'h088, 64'h6000, 8'hFF, 1'b0);
    wid = 12'h088; wdata = 64'h6001; wstrb = 8'hFF; wlast = 1'b0; wvalid = 1'b1;
    aresetn = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    cmp_cnt++;
    if (awready !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b0 || bresp !== 2'b00 ||
        bid !== 12'h0 || mem_we !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_mid_outputs aw=%b w=%b bv=%b br=%b bid=%h we=%b exp all 0",
               awready, wready, bvalid, bresp, bid, mem_we);
    end
    @(posedge clk); #1;
    aresetn = 1'b1;
    wvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cmp_cnt++;
    if (awready !== 1'b1 || bvalid !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_mid_release awready=%b bvalid=%b exp 1 0", awready, bvalid);
    end
    @(posedge clk); #1;
    run_burst(12'h099, 32'h0000_7000, 8'd1, 3'd3, BURST_INCR, 1'b1);
  endtask

  task automatic test_max_len();
    // 256 beats, address wraps past 2^32 without error
    run_burst(12'hABC, 32'hFFFF_FF00, 8'd255, 3'd3, BURST_INCR, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_burst(12'h0B1, 32'h0000_0010, 8'd3, 3'd0, BURST_INCR, 1'b1);
    run_burst(12'h0B2, 32'h0000_0040, 8'd2, 3'd1, BURST_FIXED, 1'b1);
    run_burst(12'h0B3, 32'h0000_0080, 8'd1, 3'd2, BURST_INCR, 1'b1);
  endtask

  initial begin
    aresetn = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b0; mem_wait = 1'b0;

    test_reset();
    test_incr();
    test_fixed();
    test_wlast_early();
    test_illegal();
    test_mem_wait();
    test_b_stall();
    test_reset_mid();
    test_max_len();
    test_back_to_back();

    repeat (3) @(posedge clk);
    cmp_cnt++;
    if (exp_w.size() != 0 || exp_b.size() != 0) begin
      err_cnt++;
      $display("FAIL scoreboard_drain writes_left=%0d b_left=%0d exp 0 0", exp_w.size(), exp_b.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule : tb_esaxi_wr
